// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant of ALU/LSU/MDU results into a registered
// register-file write port, plus a busy scoreboard for RAW/WAW issue stalls.
module wb_arbiter #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_alu_valid,
  output logic                    o_alu_ready,
  input  logic [$clog2(NREG)-1:0] i_alu_rd,
  input  logic [XLEN-1:0]         i_alu_data,
  input  logic                    i_lsu_valid,
  output logic                    o_lsu_ready,
  input  logic [$clog2(NREG)-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]         i_lsu_data,
  input  logic                    i_mdu_valid,
  output logic                    o_mdu_ready,
  input  logic [$clog2(NREG)-1:0] i_mdu_rd,
  input  logic [XLEN-1:0]         i_mdu_data,
  input  logic                    i_iss_valid,
  input  logic [$clog2(NREG)-1:0] i_iss_rd,
  output logic                    o_iss_ready,
  input  logic [$clog2(NREG)-1:0] i_chk_rs1,
  input  logic [$clog2(NREG)-1:0] i_chk_rs2,
  output logic                    o_chk_busy1,
  output logic                    o_chk_busy2,
  output logic                    o_we,
  output logic [$clog2(NREG)-1:0] o_waddr,
  output logic [XLEN-1:0]         o_wdata
);

  localparam int unsigned RW = $clog2(NREG);

  logic [1:0]      r_rr;
  logic            r_we;
  logic [RW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [NREG-1:0] r_busy;

  logic [2:0]      w_valid;
  logic [2:0]      w_gnt;
  logic            w_hs;
  logic [RW-1:0]   w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [1:0]      w_rr_nxt;
  logic            w_iss_ready;
  logic            w_iss_acc;
  logic [NREG-1:0] w_busy_nxt;

  assign w_valid = {i_mdu_valid, i_lsu_valid, i_alu_valid};

  // Round-robin search starting at r_rr; nothing is granted while in reset.
  always_comb begin
    w_gnt = 3'b000;
    case (r_rr)
      2'd1: begin
        if      (w_valid[1]) w_gnt = 3'b010;
        else if (w_valid[2]) w_gnt = 3'b100;
        else if (w_valid[0]) w_gnt = 3'b001;
      end
      2'd2: begin
        if      (w_valid[2]) w_gnt = 3'b100;
        else if (w_valid[0]) w_gnt = 3'b001;
        else if (w_valid[1]) w_gnt = 3'b010;
      end
      default: begin
        if      (w_valid[0]) w_gnt = 3'b001;
        else if (w_valid[1]) w_gnt = 3'b010;
        else if (w_valid[2]) w_gnt = 3'b100;
      end
    endcase
    if (i_rst) w_gnt = 3'b000;
  end

  assign w_hs       = |w_gnt;
  assign w_sel_rd   = ({RW{w_gnt[0]}} & i_alu_rd) | ({RW{w_gnt[1]}} & i_lsu_rd)
                    | ({RW{w_gnt[2]}} & i_mdu_rd);
  assign w_sel_data = ({XLEN{w_gnt[0]}} & i_alu_data) | ({XLEN{w_gnt[1]}} & i_lsu_data)
                    | ({XLEN{w_gnt[2]}} & i_mdu_data);

  always_comb begin
    w_rr_nxt = r_rr;
    if      (w_gnt[0]) w_rr_nxt = 2'd1;
    else if (w_gnt[1]) w_rr_nxt = 2'd2;
    else if (w_gnt[2]) w_rr_nxt = 2'd0;
  end

  // During reset the scoreboard is being cleared, so issue is evaluated as free.
  assign w_iss_ready = i_rst | ~r_busy[i_iss_rd] | (i_iss_rd == RW'(0));
  assign w_iss_acc   = i_iss_valid & w_iss_ready & (i_iss_rd != RW'(0));

  // Clear on writeback first so a same-edge issue to that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) w_busy_nxt[r_waddr] = 1'b0;
    if (w_iss_acc) w_busy_nxt[i_iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr    <= 2'd0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_rr   <= w_rr_nxt;
      r_busy <= w_busy_nxt;
      r_we   <= w_hs & (w_sel_rd != RW'(0));
      if (w_hs) begin
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign o_alu_ready = w_gnt[0];
  assign o_lsu_ready = w_gnt[1];
  assign o_mdu_ready = w_gnt[2];
  assign o_iss_ready = w_iss_ready;
  assign o_chk_busy1 = r_busy[i_chk_rs1];
  assign o_chk_busy2 = r_busy[i_chk_rs2];
  assign o_we        = r_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter: one record per clock cycle,
// inputs driven after the falling edge and all outputs compared before the rising edge.
module tb_wb_arbiter;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned NVEC = 28;

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [4:0]  rd_a, rd_l, rd_m;
    logic [15:0] d_a, d_l, d_m;
    logic        iv;
    logic [4:0]  ird, rs1, rs2;
    logic [2:0]  e_rdy;
    logic        e_irdy, e_b1, e_b2, e_we;
    logic [4:0]  e_wa;
    logic [15:0] e_wd;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            alu_valid, lsu_valid, mdu_valid;
  logic            alu_ready, lsu_ready, mdu_ready;
  logic [4:0]      alu_rd, lsu_rd, mdu_rd;
  logic [XLEN-1:0] alu_data, lsu_data, mdu_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            iss_ready;
  logic [4:0]      rs1, rs2;
  logic            busy1, busy2;
  logic            we;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;

  int n_checks;
  int n_pass;
  vec_t vecs [NVEC];

  wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_alu_valid (alu_valid),
    .o_alu_ready (alu_ready),
    .i_alu_rd    (alu_rd),
    .i_alu_data  (alu_data),
    .i_lsu_valid (lsu_valid),
    .o_lsu_ready (lsu_ready),
    .i_lsu_rd    (lsu_rd),
    .i_lsu_data  (lsu_data),
    .i_mdu_valid (mdu_valid),
    .o_mdu_ready (mdu_ready),
    .i_mdu_rd    (mdu_rd),
    .i_mdu_data  (mdu_data),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .i_chk_rs1   (rs1),
    .i_chk_rs2   (rs2),
    .o_chk_busy1 (busy1),
    .o_chk_busy2 (busy2),
    .o_we        (we),
    .o_waddr     (waddr),
    .o_wdata     (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int r, int v, int ra, int rl, int rm, int da, int dl, int dm,
                              int iv, int ird, int s1, int s2, int erdy, int eirdy,
                              int eb1, int eb2, int ewe, int ewa, int ewd);
    vec_t x;
    x.rst = 1'(r);     x.v = 3'(v);
    x.rd_a = 5'(ra);   x.rd_l = 5'(rl);   x.rd_m = 5'(rm);
    x.d_a = 16'(da);   x.d_l = 16'(dl);   x.d_m = 16'(dm);
    x.iv = 1'(iv);     x.ird = 5'(ird);   x.rs1 = 5'(s1);  x.rs2 = 5'(s2);
    x.e_rdy = 3'(erdy); x.e_irdy = 1'(eirdy);
    x.e_b1 = 1'(eb1);  x.e_b2 = 1'(eb2);  x.e_we = 1'(ewe);
    x.e_wa = 5'(ewa);  x.e_wd = 16'(ewd);
    return x;
  endfunction

  task automatic drive(input vec_t x);
    rst       = x.rst;
    alu_valid = x.v[0];        lsu_valid = x.v[1];        mdu_valid = x.v[2];
    alu_rd    = x.rd_a;        lsu_rd    = x.rd_l;        mdu_rd    = x.rd_m;
    alu_data  = 64'(x.d_a);    lsu_data  = 64'(x.d_l);    mdu_data  = 64'(x.d_m);
    iss_valid = x.iv;          iss_rd    = x.ird;
    rs1       = x.rs1;         rs2       = x.rs2;
  endtask

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [75:0] act, exp;
    vec_t idle;
    int   waited;

    n_checks = 0;
    n_pass   = 0;

    // Reset, single write, round-robin, x0 suppression, WAW collision, mid-op reset.
    vecs[0]  = mk(1,7, 0,0,0, 0,0,0,             0,0,  0,0,   0,1,0,0, 0,0,0);
    vecs[1]  = mk(0,0, 0,0,0, 0,0,0,             0,0,  5,0,   0,1,0,0, 0,0,0);
    vecs[2]  = mk(0,0, 0,0,0, 0,0,0,             1,5,  5,0,   0,1,0,0, 0,0,0);
    vecs[3]  = mk(0,1, 5,0,0, 'h1234,0,0,        0,5,  5,0,   1,0,1,0, 0,0,0);
    vecs[4]  = mk(0,0, 0,0,0, 0,0,0,             0,5,  5,0,   0,0,1,0, 1,5,'h1234);
    vecs[5]  = mk(0,0, 0,0,0, 0,0,0,             0,5,  5,0,   0,1,0,0, 0,5,'h1234);
    vecs[6]  = mk(0,4, 0,0,0, 0,0,0,             1,1,  1,2,   4,1,0,0, 0,5,'h1234);
    vecs[7]  = mk(0,0, 0,0,0, 0,0,0,             1,2,  1,2,   0,1,1,0, 0,0,0);
    vecs[8]  = mk(0,0, 0,0,0, 0,0,0,             1,3,  2,3,   0,1,1,0, 0,0,0);
    vecs[9]  = mk(0,7, 1,2,3, 'hA1,'hB2,'hC3,    0,0,  3,1,   1,1,1,1, 0,0,0);
    vecs[10] = mk(0,7, 1,2,3, 'hA1,'hB2,'hC3,    0,0,  3,1,   2,1,1,1, 1,1,'hA1);
    vecs[11] = mk(0,7, 1,2,3, 'hA1,'hB2,'hC3,    0,0,  3,1,   4,1,1,0, 1,2,'hB2);
    vecs[12] = mk(0,7, 1,2,3, 'hA1,'hB2,'hC3,    0,0,  2,3,   1,1,0,1, 1,3,'hC3);
    vecs[13] = mk(0,0, 0,0,0, 0,0,0,             0,0,  3,1,   0,1,0,0, 1,1,'hA1);
    vecs[14] = mk(0,2, 0,0,0, 0,'hFFFF,0,        0,0,  0,0,   2,1,0,0, 0,1,'hA1);
    vecs[15] = mk(0,7, 0,0,0, 0,0,0,             0,0,  0,0,   4,1,0,0, 0,0,'hFFFF);
    vecs[16] = mk(0,0, 0,0,0, 0,0,0,             1,7,  7,0,   0,1,0,0, 0,0,0);
    vecs[17] = mk(0,4, 0,0,7, 0,0,'h77,          1,7,  7,0,   4,0,1,0, 0,0,0);
    vecs[18] = mk(0,0, 0,0,0, 0,0,0,             1,7,  7,0,   0,0,1,0, 1,7,'h77);
    vecs[19] = mk(0,0, 0,0,0, 0,0,0,             1,7,  7,0,   0,1,0,0, 0,7,'h77);
    vecs[20] = mk(0,0, 0,0,0, 0,0,0,             0,7,  7,0,   0,0,1,0, 0,7,'h77);
    vecs[21] = mk(0,1, 9,0,0, 'h99,0,0,          0,0,  9,0,   1,1,0,0, 0,7,'h77);
    vecs[22] = mk(0,0, 0,0,0, 0,0,0,             1,9,  9,0,   0,1,0,0, 1,9,'h99);
    vecs[23] = mk(0,1, 11,0,0, 'hBB,0,0,         1,10, 9,7,   1,1,1,1, 0,9,'h99);
    vecs[24] = mk(0,1, 13,0,0, 'hDD,0,0,         1,12, 10,12, 1,1,1,0, 1,11,'hBB);
    vecs[25] = mk(1,7, 0,0,0, 0,0,0,             1,7,  7,10,  0,1,1,1, 1,13,'hDD);
    vecs[26] = mk(0,7, 0,0,0, 0,0,0,             0,9,  7,12,  1,1,0,0, 0,0,0);
    vecs[27] = mk(0,0, 0,0,0, 0,0,0,             0,0,  9,10,  0,1,0,0, 0,0,0);

    idle = mk(1,0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0);
    drive(idle);
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i]);
      #1;
      act = {mdu_ready, lsu_ready, alu_ready, iss_ready, busy1, busy2, we, waddr, wdata};
      exp = {vecs[i].e_rdy, vecs[i].e_irdy, vecs[i].e_b1, vecs[i].e_b2,
             vecs[i].e_we, vecs[i].e_wa, 64'(vecs[i].e_wd)};
      check($sformatf("vec%0d", i), act, exp);
      @(negedge clk);
    end

    // Full-width data path: ALU alone offers a 64-bit result; wait a bounded time for ready.
    idle.rst     = 1'b0;
    drive(idle);
    alu_valid = 1'b1;
    alu_rd    = 5'd4;
    alu_data  = 64'hDEAD_BEEF_0123_4567;
    waited    = 0;
    #1;
    while (!alu_ready && waited < 4) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("alu_grant_wait", 76'(waited), 76'(0));
    @(negedge clk);
    drive(idle);
    #1;
    check("wide_write", {we, waddr, wdata}, {1'b1, 5'd4, 64'hDEAD_BEEF_0123_4567});

    // Back-to-back: LSU then MDU on consecutive cycles both land, one per cycle.
    @(negedge clk);
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 64'hAAAA_0000_0000_5555;
    #1;
    check("lsu_grant", {29'd0, mdu_ready, lsu_ready, alu_ready}, {29'd0, 3'b010});
    @(negedge clk);
    lsu_valid = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd21; mdu_data = 64'h0123_4567_89AB_CDEF;
    #1;
    check("lsu_write", {we, waddr, wdata}, {1'b1, 5'd20, 64'hAAAA_0000_0000_5555});
    @(negedge clk);
    mdu_valid = 1'b0;
    #1;
    check("mdu_write", {we, waddr, wdata}, {1'b1, 5'd21, 64'h0123_4567_89AB_CDEF});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and register scoreboard for the npc core. It collects results from three execution producers (ALU, LSU, MDU) over valid/ready channels and grants one per cycle with round-robin fairness. The granted result drives the register file write port (`we`/`waddr`/`wdata`) from a registered stage. A 32-entry busy scoreboard tracks in-flight destination registers, so issue logic can stall RAW and WAW hazards on the register file's combinational read ports.

## Interface
Parameters:
- `XLEN`, 64, data width of results and of the write port.
- `NREG`, 32, number of architectural registers; index width is 5.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, input, 1, the single clock.
  - `rst`, input, 1, synchronous active-high reset.
- Producer channels, one per `p` in {alu, lsu, mdu}:
  - `p_valid`, input, 1, result offered.
  - `p_ready`, output, 1, result accepted this cycle.
  - `p_rd`, input, 5, destination register.
  - `p_data`, input, XLEN, result value.
- Issue port:
  - `iss_valid`, input, 1, instruction with a destination is issuing.
  - `iss_rd`, input, 5, its destination register.
  - `iss_ready`, output, 1, issue allowed.
- Hazard check:
  - `chk_rs1`, input, 5, source register index.
  - `chk_rs2`, input, 5, source register index.
  - `chk_busy1`, output, 1, scoreboard busy bit for `chk_rs1`.
  - `chk_busy2`, output, 1, scoreboard busy bit for `chk_rs2`.
- Register file write port:
  - `we`, output, 1, write enable.
  - `waddr`, output, 5, write address.
  - `wdata`, output, XLEN, write data.

## Operation
- Arbitration:
  - Channel order is alu=0, lsu=1, mdu=2.
  - A 2-bit round-robin pointer `rr` names the highest-priority channel. Search order is rr, rr+1, rr+2, each taken mod 3.
  - The first valid channel in search order is granted, and only its `p_ready` is asserted. `p_ready` is combinational from the valids and `rr`.
  - Ready never depends on the downstream stage, because the register file never stalls.
  - On a grant to channel g, `rr` becomes (g+1) mod 3. With no grant, `rr` holds.
- Write stage:
  - On a granted handshake, the next edge loads `we`=1, `waddr`=p_rd, `wdata`=p_data.
  - With no handshake, `we` is 0 on the next cycle. `waddr` and `wdata` hold their previous values.
  - If the granted `p_rd`==0, `we` is loaded as 0. The handshake still completes and `rr` still advances.
- Scoreboard (`busy[31:0]`):
  - `busy[0]` is hardwired to 0.
  - `iss_ready` = ~busy[iss_rd] | (iss_rd==0).
  - An accepted issue (`iss_valid & iss_ready`, iss_rd≠0) sets busy[iss_rd] at the edge.
  - A cycle with `we`=1 clears busy[waddr] at the same edge that the register file captures wdata.
  - Simultaneous set and clear on the same index: set wins.
  - `chk_busy1` and `chk_busy2` are combinational reads of `busy`. Index 0 always reads 0.
- Producers only return results for issued destinations. A result for a non-busy rd is still written, with no scoreboard side effect beyond the clear.

## Timing
- Reset values (next edge with `rst`=1): `we`=0, `waddr`=0, `wdata`=0, `rr`=0, busy=all 0.
  - All `p_ready` are 0 during reset.
  - `iss_ready` evaluates against the cleared scoreboard.
- Reset asserted mid-operation discards the in-flight write stage, all busy bits and the pointer. No write occurs on the edge where `rst`=1.
- Handshake-to-`we` latency is 1 cycle; throughput is 1 result per cycle.
- Busy clear is visible on `chk_busy*` the cycle after `we`. At that point the register file read ports already return the new data, so no bypass is needed.
- A producer holding `p_valid` without ready must hold `p_rd` and `p_data` stable. The worst-case wait is 2 cycles under contention.
- Issue-to-busy latency is 1 cycle. `chk_busy*` for a register issued this cycle reads 0; the issue stage handles that case with its own same-cycle compare.

## Test plan
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles, then all inputs 0.
  - Response: `we`=0, `waddr`=0, `wdata`=0, all `chk_busy`=0, `iss_ready`=1.
- Single write:
  - Stimulus: issue rd=5, then alu_valid with rd=5, data=0x1234 for one cycle.
  - Response: alu_ready=1, then the next cycle `we`=1, `waddr`=5, `wdata`=0x1234.
  - Response: `chk_busy1` for rs1=5 reads 1 until the cycle after `we`, then 0.
- Round-robin:
  - Stimulus: all three valid continuously with rd=1/2/3 (alu/lsu/mdu).
  - Response: grants cycle alu, lsu, mdu, alu. `waddr` sequence 1,2,3,1 with one-cycle lag.
- x0 suppression:
  - Stimulus: lsu_valid with rd=0, data=0xFFFF.
  - Response: lsu_ready=1, `we` stays 0, `rr` advances to 2.
- Set/clear collision and WAW:
  - Stimulus: busy[7] set; mdu writes rd=7 while an issue with rd=7 is offered in the same cycle as `we`=1.
  - Response: `iss_ready`=0 in that cycle.
  - Stimulus: retry issue with rd=7 once busy[7] clears.
  - Response: issue accepted and busy[7] returns to 1. Separately, a forced set+clear on the same edge leaves busy=1.
- Mid-operation reset:
  - Stimulus: `rst` pulse while `we`=1 and busy has 4 bits set.
  - Response: the next cycle shows `we`=0, all busy bits 0, `rr`=0.
